// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  // PC value the CPU starts from once cpu_hold drops; it maps to word 0.
  localparam logic [31:0] IMEM_BASE = 32'h0040_0000;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 11
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; used for the header count
// and for every data word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_in,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_stb,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready,
  output logic [1:0]  byte_cnt
);

  logic [1:0]  cnt_q;
  logic [31:0] shreg_q;
  logic [31:0] shreg_d;

  // The word is tapped from the incoming byte so the 4th byte's edge can act on it.
  assign shreg_d    = {shreg_q[23:0], byte_in};
  assign word       = shreg_d;
  assign word_ready = byte_stb && (cnt_q == 2'(WORD_BYTES - 1));
  assign byte_cnt   = cnt_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (clr) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (byte_stb) begin
      cnt_q   <= cnt_q + 2'd1;
      shreg_q <= shreg_d;
    end
  end

  logic unused_top;
  assign unused_top = ^shreg_q[31:24];

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> big-endian words -> instruction memory, holding the
// CPU in reset until the image is written. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W         = 11,
  parameter int DEPTH          = 2048,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk_in,
  input  logic          reset,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam int IDX_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  n_q, idx_q, idx_nxt;
  logic [31:0]       wdata_q;
  logic [31:0]       pk_word;
  logic [1:0]        pk_cnt;
  logic              pk_ready, rdy, accept, timeout;

  assign rdy     = (state_q == HDR) || (state_q == DATA);
  assign accept  = bus.byte_valid && rdy;
  assign idx_nxt = idx_q + IDX_W'(1);

  byte_packer u_packer (
    .clk_in     (clk_in),
    .reset      (reset),
    .clr        (!rdy),
    .byte_stb   (accept),
    .byte_in    (bus.byte_data),
    .word       (pk_word),
    .word_ready (pk_ready),
    .byte_cnt   (pk_cnt)
  );

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] gap_q;
  logic        gap_run;

  // An idle HDR (no header byte yet) is the normal pre-boot wait and never times out.
  assign gap_run = (state_q == DATA) || ((state_q == HDR) && (pk_cnt != 2'd0));
  assign timeout = gap_run && !accept && (gap_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)                  gap_q <= '0;
    else if (accept || !gap_run) gap_q <= '0;
    else                        gap_q <= gap_q + 32'd1;
  end
`else
  assign timeout = 1'b0;

  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0) | (|pk_cnt);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR: begin
        if (timeout)                          state_d = ERR;
        else if (pk_ready) begin
          // Full 32-bit count: large upper bytes must not alias into a legal size.
          if (pk_word == 32'd0)               state_d = DONE;
          else if (pk_word > 32'(DEPTH))      state_d = ERR;
          else                                state_d = DATA;
        end
      end
      DATA: begin
        if (timeout)                          state_d = ERR;
        else if (pk_ready)                    state_d = WRITE;
      end
      WRITE:   state_d = (idx_nxt == n_q) ? DONE : DATA;
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= HDR;
      n_q     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == HDR) && (state_d == DATA)) begin
        n_q   <= pk_word[IDX_W-1:0];
        idx_q <= '0;
      end
      if ((state_q == DATA) && pk_ready) wdata_q <= pk_word;
      if (state_q == WRITE)              idx_q   <= idx_nxt;
    end
  end

  assign bus.byte_ready = rdy;
  assign bus.imem_we    = (state_q == WRITE);
  assign bus.imem_addr  = idx_q[ADDR_W-1:0];
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = (state_q != DONE);
  assign done           = (state_q == DONE);
  assign err            = (state_q == ERR);

  logic unused_cfg;
  assign unused_cfg = (^IMEM_BASE) | (HDR_BYTES != WORD_BYTES);

endmodule
